// File: rtl/stream_demux_pkg.sv
// Shared constants and slot state type for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned SS_W      = 2;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_chan_slot.sv
// One-entry holding slot for a single demux output channel.
// Exposes a ready term so the top can build in_ready from the selected channel.
module demux_chan_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          ready
);

    slot_state_e   state_q, state_d;
    logic [DW-1:0] data_q;
    logic          drain;

    always_comb begin
        state_d = state_q;
        drain   = (state_q == SLOT_FULL) && out_ready;
        unique case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) data_q <= load_data;
        end
    end

    // Slot can take a word if empty or if it is being drained this cycle.
    always_comb begin
        ready     = (state_q == SLOT_EMPTY) || out_ready;
        out_valid = (state_q == SLOT_FULL);
        out_data  = data_q;
    end

endmodule

// File: rtl/stream_demux_1to4.sv
// 1-to-4 stream demultiplexer with independent per-channel holding slots.
// Define DEMUX_CNT_EN to add per-channel accepted-transfer counters.
module stream_demux_1to4
    import stream_demux_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
`ifdef DEMUX_CNT_EN
    ,
    parameter int unsigned CNT_W = DEF_CNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      in_data,
    input  logic [SS_W-1:0]    in_ss,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [NUM_CH-1:0]  out_valid,
    input  logic [NUM_CH-1:0]  out_ready
`ifdef DEMUX_CNT_EN
    ,
    input  logic               cnt_clr,
    output logic [NUM_CH*CNT_W-1:0] out_cnt
`endif
);

    logic [NUM_CH-1:0] chan_ready;
    logic [NUM_CH-1:0] load;

    // in_ready looks only at the selected channel, never at in_valid.
    always_comb begin
        in_ready = chan_ready[in_ss];
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = in_valid && in_ready && (in_ss == SS_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_chan_slot #(
            .DW (DW)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*DW +: DW]),
            .ready     (chan_ready[g])
        );
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) out_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed bench for stream_demux_1to4: vector table plus reset, throughput and counter sequences.
module tb_stream_demux_1to4;

    localparam int unsigned DW = 8;
`ifdef DEMUX_CNT_EN
    localparam int unsigned CNT_W = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_ss = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
`ifdef DEMUX_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [31:0] out_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_demux_1to4 #(
        .DW (DW)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_ss     (in_ss),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .out_cnt   (out_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  ss;
        logic [7:0]  data;
        logic        valid;
        logic [3:0]  ordy;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at negedge, check combinational in_ready, then registered outputs after the edge.
    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        in_ss     = v.ss;
        in_data   = v.data;
        in_valid  = v.valid;
        out_ready = v.ordy;
        #1;
        chk($sformatf("vec%0d in_ready", idx), {31'b0, in_ready}, {31'b0, v.exp_ready});
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d out_valid", idx), {28'b0, out_valid}, {28'b0, v.exp_valid});
        chk($sformatf("vec%0d out_data", idx), out_data, v.exp_data);
    endtask

    task automatic drive(input logic [1:0] ss, input logic [7:0] d, input logic vld,
                         input logic [3:0] ordy);
        @(negedge clk);
        in_ss     = ss;
        in_data   = d;
        in_valid  = vld;
        out_ready = ordy;
    endtask

    initial begin
        //            ss    data   vld  ordy     rdy   valid    data
        vecs[0]  = '{2'd1, 8'hA5, 1'b1, 4'b0000, 1'b1, 4'b0010, 32'h0000_A500};
        vecs[1]  = '{2'd1, 8'hA5, 1'b1, 4'b0000, 1'b0, 4'b0010, 32'h0000_A500};
        vecs[2]  = '{2'd3, 8'h5A, 1'b1, 4'b0000, 1'b1, 4'b1010, 32'h5A00_A500};
        vecs[3]  = '{2'd0, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b1011, 32'h5A00_A511};
        vecs[4]  = '{2'd0, 8'h11, 1'b1, 4'b0000, 1'b0, 4'b1011, 32'h5A00_A511};
        vecs[5]  = '{2'd0, 8'h11, 1'b1, 4'b0000, 1'b0, 4'b1011, 32'h5A00_A511};
        vecs[6]  = '{2'd0, 8'h22, 1'b0, 4'b0000, 1'b0, 4'b1011, 32'h5A00_A511};
        vecs[7]  = '{2'd0, 8'h11, 1'b1, 4'b0000, 1'b0, 4'b1011, 32'h5A00_A511};
        vecs[8]  = '{2'd2, 8'h77, 1'b0, 4'b0100, 1'b1, 4'b1011, 32'h5A00_A511};
        vecs[9]  = '{2'd0, 8'h11, 1'b0, 4'b0001, 1'b1, 4'b1010, 32'h5A00_A511};
        vecs[10] = '{2'd1, 8'h99, 1'b0, 4'b1010, 1'b1, 4'b0000, 32'h5A00_A511};
        vecs[11] = '{2'd2, 8'h33, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h5A33_A511};
        vecs[12] = '{2'd2, 8'h44, 1'b1, 4'b0100, 1'b1, 4'b0100, 32'h5A44_A511};
        vecs[13] = '{2'd3, 8'h55, 1'b1, 4'b0100, 1'b1, 4'b1000, 32'h5544_A511};
        vecs[14] = '{2'd3, 8'h66, 1'b0, 4'b0000, 1'b0, 4'b1000, 32'h5544_A511};

        // Power-on reset
        #1;
        chk("por out_valid", {28'b0, out_valid}, 32'h0);
        chk("por out_data", out_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) apply(i, vecs[i]);

        // Mid-stream reset with slot 2 full
        drive(2'd2, 8'hC3, 1'b1, 4'b0000);
        @(posedge clk);
        #1;
        chk("pre-reset out_valid", {28'b0, out_valid}, 32'h0000_000C);
        @(negedge clk);
        in_ss = 2'd1;
        rst_n = 1'b0;
        #1;
        chk("reset out_valid", {28'b0, out_valid}, 32'h0);
        chk("reset out_data", out_data, 32'h0);
`ifdef DEMUX_CNT_EN
        chk("reset out_cnt", out_cnt, 32'h0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_ss = 2'(s);
            #1;
            chk($sformatf("post-reset in_ready ss%0d", s), {31'b0, in_ready}, 32'h1);
        end
        drive(2'd2, 8'hE7, 1'b1, 4'b0000);
        @(posedge clk);
        #1;
        chk("first load out_valid", {28'b0, out_valid}, 32'h0000_0004);
        chk("first load out_data", out_data, 32'h00E7_0000);

        // Full-throughput round robin with every consumer ready
        for (int k = 0; k < 16; k++) begin
            drive(2'(k % 4), 8'(k), 1'b1, 4'b1111);
            #1;
            chk($sformatf("tput%0d in_ready", k), {31'b0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("tput%0d out_valid", k), {28'b0, out_valid}, 32'(1 << (k % 4)));
            chk($sformatf("tput%0d out_data", k), {24'b0, out_data[(k % 4)*8 +: 8]}, 32'(k));
        end
        drive(2'd0, 8'h00, 1'b0, 4'b1111);
        @(posedge clk);
        #1;
        chk("tput drained out_valid", {28'b0, out_valid}, 32'h0);
        chk("tput drained out_data", out_data, 32'h0F0E_0D0C);

`ifdef DEMUX_CNT_EN
        drive(2'd0, 8'h00, 1'b0, 4'b0000);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt clear", out_cnt, 32'h0);
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int k = 0; k < 257; k++) drive(2'd0, 8'(k), 1'b1, 4'b0001);
        @(posedge clk);
        #1;
        chk("cnt wrap", out_cnt, 32'h0000_0001);
        drive(2'd0, 8'h5C, 1'b1, 4'b0001);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt clr beats load", out_cnt, 32'h0);
        drive(2'd1, 8'h5D, 1'b1, 4'b0001);
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt ch1 inc", out_cnt, 32'h0000_0100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
